// File: rtl/dmem_ctrl_if.sv
// Data-memory controller bundle: pipeline-side request, memory bus and
// load writeback signals grouped for connection to dmem_ctrl.
interface dmem_ctrl_if #(
  parameter int WordSize = 32
);
  // Pipeline (EX/MEM stage) side
  logic                mem_valid;
  logic                mem_we;
  logic [WordSize-1:0] addr;
  logic [WordSize-1:0] wdata;
  logic [4:0]          rdn_in;
  logic                flush;
  // Data-memory request bus
  logic                dreq;
  logic                dwe;
  logic [WordSize-1:0] daddr;
  logic [WordSize-1:0] dwdata;
  logic                dack;
  logic [WordSize-1:0] drdata;
  // Pipeline control and load writeback
  logic                stall;
  logic                ld_valid;
  logic [4:0]          ld_rdn;
  logic [WordSize-1:0] ld_data;
  logic                timeout_err;

  // Controller view
  modport slave (
    input  mem_valid, mem_we, addr, wdata, rdn_in, flush, dack, drdata,
    output dreq, dwe, daddr, dwdata, stall, ld_valid, ld_rdn, ld_data, timeout_err
  );

  // Pipeline / memory view
  modport master (
    output mem_valid, mem_we, addr, wdata, rdn_in, flush, dack, drdata,
    input  dreq, dwe, daddr, dwdata, stall, ld_valid, ld_rdn, ld_data, timeout_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: issues one bus request per
// accepted load/store, holds it until dack or timeout, and returns load
// data to writeback. Flushed ops still finish on the bus but never write back.
module dmem_ctrl #(
  parameter int WordSize = 32,
  parameter int Timeout  = 16
) (
  input logic        clk,
  input logic        rstn,
  dmem_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_dreq;
  logic                r_dwe;
  logic [WordSize-1:0] r_daddr;
  logic [WordSize-1:0] r_dwdata;
  logic [4:0]          r_rdn;
  logic                r_kill;
  logic [7:0]          r_cnt;
  logic                r_ld_valid;
  logic [4:0]          r_ld_rdn;
  logic [WordSize-1:0] r_ld_data;
  logic                r_timeout_err;

  logic w_accept;
  logic w_last;

  // A new op is taken only from IDLE and only if not being flushed.
  assign w_accept = (r_state == S_IDLE) && bus.mem_valid && !bus.flush;
  // Counter holds the number of dack-less BUSY cycles already completed.
  assign w_last   = (r_cnt == 8'(Timeout - 1));

  // Request FSM with registered bus, writeback and error outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_dreq        <= 1'b0;
      r_dwe         <= 1'b0;
      r_daddr       <= '0;
      r_dwdata      <= '0;
      r_rdn         <= '0;
      r_kill        <= 1'b0;
      r_cnt         <= '0;
      r_ld_valid    <= 1'b0;
      r_ld_rdn      <= '0;
      r_ld_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_BUSY;
            r_dreq   <= 1'b1;
            r_dwe    <= bus.mem_we;
            r_daddr  <= bus.addr;
            r_dwdata <= bus.wdata;
            r_rdn    <= bus.rdn_in;
            r_kill   <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_BUSY: begin
          if (bus.dack) begin
            r_state <= S_IDLE;
            r_dreq  <= 1'b0;
            // A flush arriving with dack still kills the writeback.
            if (!r_dwe && !r_kill && !bus.flush) begin
              r_ld_valid <= 1'b1;
              r_ld_rdn   <= r_rdn;
              r_ld_data  <= bus.drdata;
            end
          end else if (w_last) begin
            r_state       <= S_IDLE;
            r_dreq        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (bus.flush) begin
              r_kill <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_dreq  <= 1'b0;
        end
      endcase
    end
  end

  // Stall upstream while an op is being taken or is still waiting on dack.
  assign bus.stall = w_accept || ((r_state == S_BUSY) && !bus.dack);

  assign bus.dreq        = r_dreq;
  assign bus.dwe         = r_dwe;
  assign bus.daddr       = r_daddr;
  assign bus.dwdata      = r_dwdata;
  assign bus.ld_valid    = r_ld_valid;
  assign bus.ld_rdn      = r_ld_rdn;
  assign bus.ld_data     = r_ld_data;
  assign bus.timeout_err = r_timeout_err;

endmodule
